// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the I/D cache memory-port arbiter.
// Both caches import this package for the FSM encoding and the default widths.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2
    } arb_state_t;

    localparam int unsigned ADDR_W_DEF     = 28;
    localparam int unsigned BLOCK_W_DEF    = 128;
    localparam int unsigned STARVE_MAX_DEF = 2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one main-memory port between the I-cache and the D-cache.
// D has priority, but I is forced through after STARVE_MAX consecutive D grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned BLOCK_W    = BLOCK_W_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic               CLK,
    input  logic               RESET,

    input  logic               I_READ,
    input  logic [ADDR_W-1:0]  I_ADDR,
    output logic [BLOCK_W-1:0] I_READDATA,
    output logic               I_BUSYWAIT,

    input  logic               D_READ,
    input  logic               D_WRITE,
    input  logic [ADDR_W-1:0]  D_ADDR,
    input  logic [BLOCK_W-1:0] D_WRITEDATA,
    output logic [BLOCK_W-1:0] D_READDATA,
    output logic               D_BUSYWAIT,

    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [ADDR_W-1:0]  MEM_ADDR,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_ACK
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t         r_state;
    logic [CNT_W-1:0]   r_starve_cnt;
    logic               r_mem_read;
    logic               r_mem_write;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [BLOCK_W-1:0] r_mem_wdata;

    logic w_d_req;
    logic w_i_starved;

    assign w_d_req     = D_READ | D_WRITE;
    assign w_i_starved = I_READ && (r_starve_cnt == STARVE_LIM);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_d_req && !w_i_starved) begin
                        r_state     <= GRANT_D;
                        r_mem_addr  <= D_ADDR;
                        r_mem_wdata <= D_WRITEDATA;
                        // A simultaneous read is left pending behind the write-back.
                        r_mem_write <= D_WRITE;
                        r_mem_read  <= ~D_WRITE;
                        if (!I_READ) begin
                            r_starve_cnt <= '0;
                        end else if (r_starve_cnt != STARVE_LIM) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end else if (I_READ) begin
                        r_state      <= GRANT_I;
                        r_mem_addr   <= I_ADDR;
                        r_mem_wdata  <= '0;
                        r_mem_write  <= 1'b0;
                        r_mem_read   <= 1'b1;
                        r_starve_cnt <= '0;
                    end
                end
                GRANT_D, GRANT_I: begin
                    // Grant holds until the ack regardless of the requester's lines.
                    if (MEM_ACK) begin
                        r_state     <= IDLE;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign MEM_READ      = r_mem_read;
    assign MEM_WRITE     = r_mem_write;
    assign MEM_ADDR      = r_mem_addr;
    assign MEM_WRITEDATA = r_mem_wdata;

    assign I_READDATA = MEM_READDATA;
    assign D_READDATA = MEM_READDATA;

    assign I_BUSYWAIT = I_READ  & ~((r_state == GRANT_I) & MEM_ACK);
    assign D_BUSYWAIT = w_d_req & ~((r_state == GRANT_D) & MEM_ACK);

endmodule
